pc_fetch_ctrl: RTL
==================

# pc_fetch_ctrl

Fetch-stage controller directly upstream of the PC target adder. Owns the architectural PC register and issues instruction-memory requests with a single-outstanding handshake. Buffers returned instructions in a 2-entry queue toward decode. Redirects to the target produced by the PC target adder, discarding any in-flight fetch, and feeds the adder's `iPC` with the PC of the instruction leaving the queue.

## Interface
Parameters:
- `RESET_VECTOR`, 32'h0000_0000, PC loaded on reset
- `QDEPTH`, 2, instruction queue entries (power of two, ≥2)

Ports:
- `iClk`  in  1  clock; all state updates on rising edge
- `iRst`  in  1  reset; synchronous, active-high
- `iRedirect`  in  1  taken branch/jump resolved this cycle
- `iPCTarget`  in  32  redirect target (the adder's `oPCTarget`)
- `iStall`  in  1  hazard stall; freezes fetch issue, queue contents held
- `oIMemReq`  out  1  instruction-memory request valid
- `oIMemAddr`  out  32  request address
- `iIMemValid`  in  1  response valid (≥1 cycle after request accepted)
- `iIMemData`  in  32  response instruction word
- `oInstValid`  out  1  queue head valid to decode
- `oInst`  out  32  queue head instruction
- `oInstPC`  out  32  queue head PC (drives adder `iPC`)
- `iDecodeReady`  in  1  decode consumes head this cycle
- `oMisalign`  out  1  misaligned redirect flag (only with `FETCH_MISALIGN_CHECK_EN`)

## Operation
- FSM states: `RUN` (no outstanding request), `WAIT` (request outstanding, response wanted), `DRAIN` (request outstanding, response to be discarded).
- `RUN`: assert `oIMemReq` with `oIMemAddr`=PC when `!iStall && !iRedirect` and free slots (QDEPTH − count) ≥1. A request is accepted the cycle it is asserted. On issue: PC←PC+4, go `WAIT`.
- `WAIT`: on `iIMemValid`, push {`iIMemData`, request PC} to queue, go `RUN`. The same-cycle re-issue is not allowed; the next request is issued no earlier than the following cycle.
- `iRedirect`: flush queue (count←0), PC←`iPCTarget`. From `WAIT` go to `DRAIN`. If `iIMemValid` coincides with the redirect, drop the data and go to `RUN`. From `RUN` stay in `RUN`; no request that cycle.
- `DRAIN`: on `iIMemValid`, drop the data, go `RUN`. A second `iRedirect` in `DRAIN` updates PC only.
- Redirect has priority over stall, push, and pop in the same cycle.
- Queue: circular, `$clog2(QDEPTH)`-bit pointers wrap modulo QDEPTH. Simultaneous push and pop with count=QDEPTH is impossible by issue rule. Push and pop with count=0 is not bypassed; head appears the next cycle.
- Pop when `oInstValid && iDecodeReady && !iRedirect`.
- PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC→0.

## Timing
- Reset (synchronous): PC=`RESET_VECTOR`, state `RUN`, count=0, pointers=0. All outputs are 0, except `oIMemAddr`=`RESET_VECTOR`.
- First request is issued the cycle after `iRst` deasserts.
- Zero-wait memory (valid 1 cycle after request): one instruction every 2 cycles. Redirect-to-request latency is 1 cycle.
- Outputs `oInst*` are registered (queue read); `oIMemReq` is combinational from state, count, `iStall`, and `iRedirect`.
- Reset asserted in any state (including `DRAIN`) returns to reset values. A late `iIMemValid` arriving in `RUN` after reset is ignored.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined: when a redirect has `iPCTarget[1:0]`≠0, set sticky `oMisalign`, load PC, and block further requests until reset.
- Undefined: `oMisalign` tied 0, `iPCTarget[1:0]` forced to 2'b00 when loaded.

## Structure
- Shared package: `FetchState_t` enum (`RUN`, `WAIT`, `DRAIN`), `PC_INCR`=32'd4, and the existing `InstructionSubTypes`.
- One sub-module: `fetch_queue` (parameterised circular FIFO, push/pop/flush, count, full/empty).

## Test plan
- Reset with `RESET_VECTOR`=32'h100, zero-wait memory → requests at 0x100, 0x104, 0x108; `oInstPC` sequence matches and is in order.
- `iDecodeReady`=0 held → exactly 2 entries are queued, then `oIMemReq` stays 0 until a pop.
- `iRedirect` with target 0x200 while in `WAIT`, response returns 3 cycles later → response dropped, queue empty, next request 0x200.
- `iRedirect` coincident with `iIMemValid` and pop → nothing pushed or popped, count=0, next request is at the target.
- `iStall`=1 for 5 cycles in `RUN` → no request and PC unchanged; resumes at the same address.
- With `FETCH_MISALIGN_CHECK_EN`: redirect to 0x202 → `oMisalign`=1 next cycle, no further requests. Without the macro: next request address is 0x200.

Source files
------------

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage controller and its queue.
package pc_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } FetchState_t;

    localparam logic [31:0] PC_INCR = 32'd4;

    typedef enum logic [2:0] {
        ALU_TYPE    = 3'd0,
        LOAD_TYPE   = 3'd1,
        STORE_TYPE  = 3'd2,
        BRANCH_TYPE = 3'd3,
        JUMP_TYPE   = 3'd4,
        SYSTEM_TYPE = 3'd5
    } InstructionSubTypes;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO between fetch and decode; flush empties it in one cycle.
module fetch_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rptr];
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch controller: owns the PC, issues single-outstanding imem requests, queues fetched words.
// Optional FETCH_MISALIGN_CHECK_EN flags misaligned redirect targets and halts fetch until reset.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned QDEPTH       = 2
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iRedirect,
    input  logic [31:0] iPCTarget,
    input  logic        iStall,
    output logic        oIMemReq,
    output logic [31:0] oIMemAddr,
    input  logic        iIMemValid,
    input  logic [31:0] iIMemData,
    output logic        oInstValid,
    output logic [31:0] oInst,
    output logic [31:0] oInstPC,
    input  logic        iDecodeReady,
    output logic        oMisalign
);
    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    FetchState_t      state;
    logic [31:0]      pc;
    logic [31:0]      req_pc;
    logic [31:0]      target;
    logic             misalign;
    logic             issue;
    logic             push;
    logic             pop;
    logic [63:0]      q_rdata;
    logic [CW-1:0]    q_count;
    logic             q_full;
    logic             q_empty;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign target = iPCTarget;

    // Sticky until reset; blocks all further issue.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            misalign <= 1'b0;
        end else if (iRedirect && (iPCTarget[1:0] != 2'b00)) begin
            misalign <= 1'b1;
        end
    end
`else
    assign target   = align_pc(iPCTarget);
    assign misalign = 1'b0;
`endif

    // Free-slot rule: issue only while at least one queue entry is unclaimed.
    assign issue = !iRst && (state == RUN) && !iStall && !iRedirect &&
                   (q_count != CW'(QDEPTH)) && !misalign;
    assign push  = (state == WAIT) && iIMemValid && !iRedirect && !q_full;
    assign pop   = !q_empty && iDecodeReady && !iRedirect;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state  <= RUN;
            pc     <= RESET_VECTOR;
            req_pc <= RESET_VECTOR;
        end else if (iRedirect) begin
            pc <= target;
            // A response coinciding with the redirect is the one we would drain.
            if ((state != RUN) && !iIMemValid) begin
                state <= DRAIN;
            end else begin
                state <= RUN;
            end
        end else begin
            unique case (state)
                RUN: begin
                    if (issue) begin
                        req_pc <= pc;
                        pc     <= pc + PC_INCR;
                        state  <= WAIT;
                    end
                end
                WAIT, DRAIN: begin
                    if (iIMemValid) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (64)
    ) u_queue (
        .clk   (iClk),
        .rst   (iRst),
        .push  (push),
        .pop   (pop),
        .flush (iRedirect),
        .wdata ({iIMemData, req_pc}),
        .rdata (q_rdata),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    assign oIMemReq   = issue;
    assign oIMemAddr  = pc;
    assign oInstValid = !q_empty;
    assign oInst      = q_empty ? 32'h0 : q_rdata[63:32];
    assign oInstPC    = q_empty ? 32'h0 : q_rdata[31:0];
    assign oMisalign  = misalign;

endmodule
